// File: rtl/proc_cache_ctrl.sv
// Direct-mapped cache tag controller.
// Accepts one processor read or write at a time and looks up its tag.
// On a miss it fetches the block over the bus and writes the new tag into the tag array.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters (hit_cnt, miss_cnt).
module proc_cache_ctrl #(
    parameter int ADDR_WID   = 32,
    parameter int TAG_MSB    = 31,
    parameter int TAG_LSB    = 20,
    parameter int INDEX_MSB  = 19,
    parameter int INDEX_LSB  = 2,
    parameter int OFFSET_MSB = 1,
    parameter int OFFSET_LSB = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_rd,
    input  logic                         cmd_wr,
    input  logic [ADDR_WID-1:0]          address,
    output logic                         proc_stall,
    output logic                         proc_done,
    output logic                         hit,
    output logic                         cmd_err,
    output logic                         tag_arr_en,
    output logic                         tag_arr_we,
    output logic [INDEX_MSB-INDEX_LSB:0] tag_arr_index,
    output logic [TAG_MSB-TAG_LSB:0]     tag_arr_wtag,
    input  logic [TAG_MSB-TAG_LSB:0]     tag_arr_rtag,
    input  logic                         tag_arr_rvalid,
    output logic                         bus_req,
    output logic [ADDR_WID-1:0]          bus_addr,
    input  logic                         bus_gnt,
    input  logic                         bus_done
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]                  hit_cnt,
    output logic [15:0]                  miss_cnt
`endif
);

    localparam int TAG_W = TAG_MSB - TAG_LSB + 1;
    localparam int IDX_W = INDEX_MSB - INDEX_LSB + 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOOKUP   = 3'd1;
    localparam logic [2:0] BUS_REQ  = 3'd2;
    localparam logic [2:0] BUS_WAIT = 3'd3;
    localparam logic [2:0] FILL     = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    logic [2:0]          state_q;
    logic [ADDR_WID-1:0] addr_q;
    logic [ADDR_WID-1:0] blk_addr;
    logic [ADDR_WID-1:0] bus_addr_q;
    logic [IDX_W-1:0]    index_q;
    logic [TAG_W-1:0]    wtag_q;
    logic                hit_q;
    logic                accept;
    logic                lookup_hit;

    // Exactly one command while idle starts a transaction; reset blocks acceptance so outputs stay zero.
    assign accept     = rst_n && (state_q == IDLE) && (cmd_rd ^ cmd_wr);
    assign lookup_hit = tag_arr_rvalid && (tag_arr_rtag == addr_q[TAG_MSB:TAG_LSB]);

    assign proc_stall    = (state_q != IDLE);
    assign proc_done     = (state_q == DONE);
    assign hit           = (state_q == DONE) && hit_q;
    assign cmd_err       = rst_n && (state_q == IDLE) && cmd_rd && cmd_wr;
    assign tag_arr_en    = accept;
    assign tag_arr_we    = (state_q == FILL);
    assign tag_arr_index = accept ? address[INDEX_MSB:INDEX_LSB] : index_q;
    assign tag_arr_wtag  = wtag_q;
    assign bus_req       = (state_q == BUS_REQ);
    assign bus_addr      = bus_addr_q;

    // Block-aligned form of the latched address, used for the refill request.
    always_comb begin
        blk_addr = addr_q;
        blk_addr[OFFSET_MSB:OFFSET_LSB] = '0;
    end

    // Transaction sequencer: lookup, optional bus refill and tag write, then a one-cycle completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            bus_addr_q <= '0;
            index_q    <= '0;
            wtag_q     <= '0;
            hit_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= address;
                        index_q <= address[INDEX_MSB:INDEX_LSB];
                        hit_q   <= 1'b0;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_q <= lookup_hit;
                    if (lookup_hit) begin
                        state_q <= DONE;
                    end else begin
                        bus_addr_q <= blk_addr;
                        state_q    <= BUS_REQ;
                    end
                end
                BUS_REQ: begin
                    if (bus_gnt) begin
                        state_q <= BUS_WAIT;
                    end
                end
                BUS_WAIT: begin
                    if (bus_done) begin
                        index_q <= addr_q[INDEX_MSB:INDEX_LSB];
                        wtag_q  <= addr_q[TAG_MSB:TAG_LSB];
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Count lookup outcomes, saturating so the counters never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == LOOKUP) begin
            if (lookup_hit) begin
                if (hit_cnt != 16'hFFFF) begin
                    hit_cnt <= hit_cnt + 16'd1;
                end
            end else begin
                if (miss_cnt != 16'hFFFF) begin
                    miss_cnt <= miss_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_proc_cache_ctrl.sv
// Scoreboard bench for proc_cache_ctrl: a direct-mapped cache model predicts hit/miss,
// a tag-array and bus responder emulate the environment, and a monitor checks every completion.
`timescale 1ns/1ps
module tb_proc_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_rd;
    logic        cmd_wr;
    logic [31:0] address;
    logic        proc_stall;
    logic        proc_done;
    logic        hit;
    logic        cmd_err;
    logic        tag_arr_en;
    logic        tag_arr_we;
    logic [17:0] tag_arr_index;
    logic [11:0] tag_arr_wtag;
    logic [11:0] tag_arr_rtag;
    logic        tag_arr_rvalid;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_gnt;
    logic        bus_done;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    proc_cache_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_rd         (cmd_rd),
        .cmd_wr         (cmd_wr),
        .address        (address),
        .proc_stall     (proc_stall),
        .proc_done      (proc_done),
        .hit            (hit),
        .cmd_err        (cmd_err),
        .tag_arr_en     (tag_arr_en),
        .tag_arr_we     (tag_arr_we),
        .tag_arr_index  (tag_arr_index),
        .tag_arr_wtag   (tag_arr_wtag),
        .tag_arr_rtag   (tag_arr_rtag),
        .tag_arr_rvalid (tag_arr_rvalid),
        .bus_req        (bus_req),
        .bus_addr       (bus_addr),
        .bus_gnt        (bus_gnt),
        .bus_done       (bus_done)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] addr;
        bit          exp_hit;
        bit          en_seen;
        int          en_cyc;
        int          we_cnt;
        int          req_cycles;
        int          exp_req;
    } sb_entry_t;

    sb_entry_t   sb [$];
    logic [11:0] ref_tag [int];
    logic [12:0] env_mem [int];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gnt_delay;
    bit hold_done;
    int resp_phase;
    int last_done_cyc;

    logic [11:0] pool_tag [3] = '{12'h123, 12'h456, 12'hABC};
    logic [17:0] pool_idx [3] = '{18'h00010, 18'h00011, 18'h3FFFF};

    // Free-running cycle count used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Predict the outcome with a direct-mapped cache model and queue it.
    task automatic pushExpect(input logic rd, input logic wr, input logic [31:0] a, input int exp_req);
        sb_entry_t e;
        int        idx;
        e = '{default: 0};
        e.addr    = a;
        e.exp_req = exp_req;
        if (rd && wr) begin
            e.is_err = 1'b1;
        end else begin
            idx = int'(a[19:2]);
            e.exp_hit = ref_tag.exists(idx) && (ref_tag[idx] == a[31:20]);
            if (!e.exp_hit) ref_tag[idx] = a[31:20];
        end
        sb.push_back(e);
    endtask

    // Issue one command at posedge+1 and wait until the monitor has retired it.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a, input int exp_req);
        pushExpect(rd, wr, a, exp_req);
        cmd_rd  = rd;
        cmd_wr  = wr;
        address = a;
        @(posedge clk); #1;
        cmd_rd  = 1'b0;
        cmd_wr  = 1'b0;
        address = $urandom;
        if (rd && wr) checkOutput("err_stall_after", 32'(proc_stall), 0);
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            if (proc_stall) begin
                cmd_rd  = 1'($urandom);
                cmd_wr  = 1'($urandom);
                address = $urandom;
            end else begin
                cmd_rd = 1'b0;
                cmd_wr = 1'b0;
            end
            @(posedge clk); #1;
        end
        cmd_rd = 1'b0;
        cmd_wr = 1'b0;
        checkOutput("drain", sb.size(), 0);
        sb.delete();
    endtask

    // Tag array: sample requests before the edge, answer one cycle later, store fills.
    initial begin
        logic        en_s, we_s;
        logic [17:0] idx_s;
        logic [11:0] wtag_s;
        tag_arr_rtag   = '0;
        tag_arr_rvalid = 1'b0;
        forever begin
            @(negedge clk);
            en_s   = tag_arr_en;
            we_s   = tag_arr_we;
            idx_s  = tag_arr_index;
            wtag_s = tag_arr_wtag;
            @(posedge clk); #1;
            if (we_s) env_mem[int'(idx_s)] = {1'b1, wtag_s};
            if (en_s && env_mem.exists(int'(idx_s))) begin
                tag_arr_rvalid = env_mem[int'(idx_s)][12];
                tag_arr_rtag   = env_mem[int'(idx_s)][11:0];
            end else if (en_s) begin
                tag_arr_rvalid = 1'b0;
                tag_arr_rtag   = 12'($urandom);
            end else begin
                tag_arr_rvalid = 1'($urandom);
                tag_arr_rtag   = 12'($urandom);
            end
        end
    end

    // Bus responder: grant after gnt_delay request cycles, finish a few cycles later, junk elsewhere.
    initial begin
        int low_cnt;
        int wait_cnt;
        bus_gnt    = 1'b0;
        bus_done   = 1'b0;
        resp_phase = 0;
        low_cnt    = 0;
        wait_cnt   = 0;
        forever begin
            @(negedge clk);
            bus_gnt  = 1'b0;
            bus_done = 1'b0;
            if (!rst_n) begin
                resp_phase = 0;
                low_cnt    = 0;
            end else if (resp_phase == 0) begin
                bus_done = ($urandom_range(0, 3) == 0);
                if (bus_req) begin
                    if (low_cnt >= gnt_delay) begin
                        bus_gnt    = 1'b1;
                        resp_phase = 1;
                        low_cnt    = 0;
                        wait_cnt   = $urandom_range(0, 3);
                    end else begin
                        low_cnt++;
                    end
                end else begin
                    bus_gnt = ($urandom_range(0, 3) == 0);
                end
            end else begin
                if (!hold_done && wait_cnt == 0) begin
                    bus_done      = 1'b1;
                    last_done_cyc = cyc;
                    resp_phase    = 0;
                end else begin
                    if (wait_cnt > 0) wait_cnt--;
                    bus_gnt = 1'($urandom);
                end
            end
        end
    end

    // Monitor: match DUT activity to the head of the scoreboard on every falling edge.
    initial begin
        sb_entry_t   e;
        logic [31:0] blk;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
            end else if (sb.size() == 0) begin
                if (tag_arr_en || cmd_err || proc_done || bus_req || tag_arr_we)
                    checkOutput("idle_activity", {27'b0, tag_arr_en, cmd_err, proc_done, bus_req, tag_arr_we}, 0);
            end else if (sb[0].is_err) begin
                if (cmd_err) begin
                    checkOutput("err_no_lookup", 32'(tag_arr_en), 0);
                    checkOutput("err_no_stall", 32'(proc_stall), 0);
                    void'(sb.pop_front());
                end else if (tag_arr_en) begin
                    checkOutput("err_accepted", 32'(tag_arr_en), 0);
                end
            end else begin
                blk = {sb[0].addr[31:2], 2'b00};
                if (cmd_err) checkOutput("err_during_access", 32'(cmd_err), 0);
                if (tag_arr_en && sb[0].en_seen) begin
                    checkOutput("accept_while_stalled", 32'(tag_arr_en), 0);
                end else if (tag_arr_en) begin
                    checkOutput("lookup_index", 32'(tag_arr_index), 32'(sb[0].addr[19:2]));
                    sb[0].en_seen = 1'b1;
                    sb[0].en_cyc  = cyc;
                end
                if (bus_req) begin
                    sb[0].req_cycles++;
                    checkOutput("bus_addr", bus_addr, blk);
                    checkOutput("bus_req_stall", 32'(proc_stall), 1);
                end else if (proc_stall && sb[0].req_cycles > 0) begin
                    checkOutput("bus_addr_hold", bus_addr, blk);
                end
                if (tag_arr_we) begin
                    sb[0].we_cnt++;
                    checkOutput("fill_index", 32'(tag_arr_index), 32'(sb[0].addr[19:2]));
                    checkOutput("fill_tag", 32'(tag_arr_wtag), 32'(sb[0].addr[31:20]));
                end
                if (proc_done) begin
                    e = sb.pop_front();
                    checkOutput("done_hit", 32'(hit), 32'(e.exp_hit));
                    checkOutput("done_stall", 32'(proc_stall), 1);
                    if (e.exp_hit) begin
                        checkOutput("hit_latency", cyc - e.en_cyc, 2);
                        checkOutput("hit_no_bus", e.req_cycles, 0);
                        checkOutput("hit_no_fill", e.we_cnt, 0);
                    end else begin
                        checkOutput("miss_latency", cyc - last_done_cyc, 2);
                        checkOutput("miss_fill_once", e.we_cnt, 1);
                        if (e.exp_req > 0) checkOutput("req_cycles", e.req_cycles, e.exp_req);
                    end
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence: directed cases first, then randomized traffic.
    initial begin
        rst_n     = 1'b0;
        cmd_rd    = 1'b0;
        cmd_wr    = 1'b0;
        address   = '0;
        gnt_delay = 0;
        hold_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_outputs",
                    {24'b0, proc_stall, proc_done, hit, cmd_err, tag_arr_en, tag_arr_we, bus_req, 1'b0}, 0);
        checkOutput("rst_index", 32'(tag_arr_index), 0);
        checkOutput("rst_wtag", 32'(tag_arr_wtag), 0);
        checkOutput("rst_bus_addr", bus_addr, 0);
`ifdef CACHE_STATS_EN
        checkOutput("rst_hit_cnt", 32'(hit_cnt), 0);
        checkOutput("rst_miss_cnt", 32'(miss_cnt), 0);
`endif
        rst_n = 1'b1;

        env_mem['h3C000] = 13'h1FFF;
        ref_tag['h3C000] = 12'hFFF;
        applyStimulus(1'b1, 1'b0, 32'hFFFF_0000, 0);

        gnt_delay = 1;
        applyStimulus(1'b0, 1'b1, 32'hFEED_C0DE, 2);
`ifdef CACHE_STATS_EN
        checkOutput("stats_hit_cnt", 32'(hit_cnt), 1);
        checkOutput("stats_miss_cnt", 32'(miss_cnt), 1);
`endif

        env_mem['h0043F] = 13'h1C01;
        ref_tag['h0043F] = 12'hC01;
        gnt_delay = 5;
        applyStimulus(1'b1, 1'b0, 32'hC000_10FF, 6);

        applyStimulus(1'b1, 1'b1, 32'hABCD_DCBA, 0);

        gnt_delay = 1000;
        pushExpect(1'b1, 1'b0, 32'h2333_2333, 0);
        cmd_rd  = 1'b1;
        address = 32'h2333_2333;
        @(posedge clk); #1;
        cmd_rd = 1'b0;
        for (int i = 0; i < 20 && !bus_req; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("reach_bus_req", 32'(bus_req), 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_bus_req", 32'(bus_req), 0);
        checkOutput("rst_async_stall_a", 32'(proc_stall), 0);
        sb.delete();
        ref_tag.delete('h0C8CC);
        gnt_delay = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        hold_done = 1'b1;
        pushExpect(1'b1, 1'b0, 32'h2333_2333, 0);
        cmd_rd  = 1'b1;
        address = 32'h2333_2333;
        @(posedge clk); #1;
        cmd_rd = 1'b0;
        for (int i = 0; i < 20 && resp_phase != 1; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("reach_bus_wait", resp_phase, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_stall_w", 32'(proc_stall), 0);
        checkOutput("rst_no_done", 32'(proc_done), 0);
        sb.delete();
        ref_tag.delete('h0C8CC);
        hold_done = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h2333_2333, 1);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int          k;
            k = $urandom_range(0, 7);
            a = {pool_tag[$urandom_range(0, 2)], pool_idx[$urandom_range(0, 2)], 2'($urandom)};
            gnt_delay = $urandom_range(0, 3);
            if (k == 0)     applyStimulus(1'b1, 1'b1, a, 0);
            else if (k < 4) applyStimulus(1'b1, 1'b0, a, gnt_delay + 1);
            else            applyStimulus(1'b0, 1'b1, a, gnt_delay + 1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
